// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared constants and types for data-memory port initiators.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int c_mem_dw = 8;
    localparam int c_mem_aw = 8;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = c_st_idle,
        READ  = c_st_read,
        WRITE = c_st_write,
        DONE  = c_st_done
    } state_t;

    // One memory-port request as seen by the external port mux.
    typedef struct packed {
        logic                rd;
        logic                wr;
        logic [c_mem_aw-1:0] addr;
        logic [c_mem_dw-1:0] wdata;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_copy_engine.sv
// ============================================================================
// Module  : mem_copy_engine
// Brief   : Byte-wise SRC->DST block copier on the data-memory port with a
//           running mod-2^DW checksum of the copied bytes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int DW = c_mem_dw,
    parameter int AW = c_mem_aw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] WriteData,
    input  logic [DW-1:0] ReadData
);

    localparam logic [AW-1:0] c_one = 1;

    state_t        r_state;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_buf;
    logic [DW-1:0] r_checksum;
    logic [AW-1:0] w_idx_inc;

    assign w_idx_inc = r_idx + c_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_buf      <= '0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src      <= src;
                        r_dst      <= dst;
                        r_len      <= len;
                        r_idx      <= '0;
                        r_checksum <= '0;
                        r_state    <= (len != '0) ? READ : DONE;
                    end
                end
                READ: begin
                    r_buf      <= ReadData;
                    r_checksum <= r_checksum + ReadData;
                    r_state    <= WRITE;
                end
                WRITE: begin
                    r_idx   <= w_idx_inc;
                    r_state <= (w_idx_inc == r_len) ? DONE : READ;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Port outputs decode registered state only, so an async reset clears
    // them immediately and they are settled well before every edge.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        case (r_state)
            READ: begin
                MemRead = 1'b1;
                Address = r_src + r_idx;
            end
            WRITE: begin
                MemWrite  = 1'b1;
                Address   = r_dst + r_idx;
                WriteData = r_buf;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign checksum = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// Module  : tb_mem_copy_engine
// Brief   : Self-checking bench for mem_copy_engine against a byte-array model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] Address;
    logic [7:0] WriteData;
    logic [7:0] ReadData;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;

    // Expected per-cycle {busy, done, MemRead, MemWrite, Address, WriteData}
    logic [19:0] exp_q [$];

    int vectors;
    int miscompares;
    int cs;
    int cs1;
    int cs2;

    mem_copy_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: write at posedge, read data presented from the negedge.
    always @(posedge clk) begin
        if (MemWrite) mem[Address] <= WriteData;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    always @(negedge clk) begin
        if (MemRead) ReadData <= mem[Address];
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, o, e);
        end
    endtask

    function automatic logic [19:0] obs();
        return {busy, done, MemRead, MemWrite, Address, WriteData};
    endfunction

    // Forward byte-by-byte copy on a snapshot of the memory; only the first
    // ncommit bytes are committed to the reference image.
    function automatic int build(input logic [7:0] s, input logic [7:0] d,
                                 input logic [7:0] l, input int ncommit);
        logic [7:0] m [256];
        logic [7:0] b;
        int sum;
        sum = 0;
        for (int i = 0; i < 256; i++) m[i] = ref_mem[i];
        for (int i = 0; i < int'(l); i++) begin
            b = m[8'(int'(s) + i)];
            sum += int'(b);
            exp_q.push_back({4'b1010, 8'(int'(s) + i), 8'h00});
            exp_q.push_back({4'b1001, 8'(int'(d) + i), b});
            m[8'(int'(d) + i)] = b;
            if (i < ncommit) ref_mem[8'(int'(d) + i)] = b;
        end
        exp_q.push_back({4'b1100, 16'h0000});
        return sum % 256;
    endfunction

    task automatic monitor(input string tag);
        int n;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s.cyc%0d", tag, k + 1), 32'(obs()), 32'(exp_q[k]));
        end
        exp_q.delete();
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check(tag, diffs, 0);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = v;
        ref_mem[a] = v;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic simple_xfer(input string tag, input logic [7:0] s,
                               input logic [7:0] d, input logic [7:0] l,
                               output int sum);
        sum = build(s, d, l, 256);
        exp_q.push_back(20'h0);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        fork
            monitor(tag);
            begin
                @(negedge clk);
                start = 1'b0;
                src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom);
            end
        join
        check({tag, ".checksum"}, 32'(checksum), sum);
        check_mem({tag, ".mem"});
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0; ReadData = '0;

        @(negedge clk);
        check("reset", 32'({obs(), checksum}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_addr = 8'(i); tb_data = 8'($urandom);
            ref_mem[i] = tb_data;
        end
        @(negedge clk);
        tb_we = 1'b0;

        // Basic copy
        poke(8'd100, 8'd1); poke(8'd101, 8'd2); poke(8'd102, 8'd4); poke(8'd103, 8'd7);
        simple_xfer("basic", 8'd100, 8'd200, 8'd4, cs);
        check("basic.sum14", 32'(checksum), 14);

        // Zero length
        simple_xfer("zero", 8'd30, 8'd60, 8'd0, cs);
        check("zero.sum0", 32'(checksum), 0);

        // Wrap-around and checksum overflow
        poke(8'd254, 8'd200); poke(8'd255, 8'd100); poke(8'd0, 8'd3); poke(8'd1, 8'd9);
        simple_xfer("wrap", 8'd254, 8'd10, 8'd4, cs);
        check("wrap.sum56", 32'(checksum), 56);

        // Overlap with a start pulse while busy
        poke(8'd100, 8'd1); poke(8'd101, 8'd2); poke(8'd102, 8'd4);
        cs = build(8'd100, 8'd101, 8'd3, 256);
        exp_q.push_back(20'h0);
        @(negedge clk);
        start = 1'b1; src = 8'd100; dst = 8'd101; len = 8'd3;
        fork
            monitor("ovl");
            begin
                @(negedge clk); start = 1'b0;
                @(negedge clk); start = 1'b1; src = 8'd50; dst = 8'd60; len = 8'd1;
                @(negedge clk); start = 1'b0;
            end
        join
        check("ovl.checksum", 32'(checksum), cs);
        check_mem("ovl.mem");
        check("ovl.m103", 32'(mem[103]), 1);

        // Back-to-back with start held high
        cs1 = build(8'd20, 8'd120, 8'd3, 256);
        exp_q.push_back(20'h0);
        cs2 = build(8'd40, 8'd140, 8'd2, 256);
        exp_q.push_back(20'h0);
        @(negedge clk);
        start = 1'b1; src = 8'd20; dst = 8'd120; len = 8'd3;
        fork
            monitor("b2b");
            begin
                @(negedge clk); src = 8'd40; dst = 8'd140; len = 8'd2;
                repeat (8) @(negedge clk);
                start = 1'b0;
            end
        join
        check("b2b.checksum", 32'(checksum), cs2);
        check_mem("b2b.mem");

        // Reset during the third WRITE cycle
        cs = build(8'd150, 8'd180, 8'd10, 2);
        @(negedge clk);
        start = 1'b1; src = 8'd150; dst = 8'd180; len = 8'd10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            check($sformatf("rst.cyc%0d", k + 1), 32'(obs()), 32'(exp_q[k]));
        end
        exp_q.delete();
        #2 rst = 1'b1;
        #1 check("rst.async", 32'({obs(), checksum}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.idle", 32'({obs(), checksum}), 0);
        check_mem("rst.mem");

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            simple_xfer($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom),
                        8'($urandom_range(0, 20)), cs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
